axi_bram_responder: RTL and testbench

AXI_BRAM_RESPONDER -- requirements
Module: axi_bram_responder

---
 rtl/axi_bram_responder_pkg.sv | 21 ++
 rtl/axi_bram_responder_ram.sv | 38 +++
 rtl/axi_bram_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_bram_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bram_responder_pkg.sv
// Purpose : shared constants and FSM encoding for the AXI block-RAM responder.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package axi_bram_responder_pkg;

  // AXI write/read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI burst length field width (beats-1)
  localparam int LEN_W = 8;

  // One burst is served at a time; IDLE is the only state that accepts addresses.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_t;

endpackage

// File: rtl/axi_bram_responder_ram.sv
// Purpose : single-port RAM, per-byte write enable, synchronous read (read-before-write).
// Latency : read data valid 1 cycle after i_en; o_rdata holds while i_en is low.
// Backpressure: none; caller stalls by holding i_en low.
// Ports   : i_clk clock, i_en access enable, i_we byte write enables,
//           i_addr word index, i_wdata write data, o_rdata registered read data.
// Contents are neither reset nor initialised.
module byte_enable_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    i_clk,
  input  logic                    i_en,
  input  logic [DATA_WIDTH/8-1:0] i_we,
  input  logic [ADDR_BITS-1:0]    i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_we[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_bram_responder.sv
// Purpose : AXI4 slave (INCR, full-width bursts only) in front of a byte-enable block RAM.
// Latency : first R beat 2 cycles after the AR handshake, then 1 beat/cycle; B after the last W beat.
// Backpressure: rready low freezes the R pipeline with outputs held; bready low stalls in WRESP.
// Ports   : aclk/resetn (sync, active-low); s_axi_aw*/w*/b* write channels;
//           s_axi_ar*/r* read channels. Address bits outside the word index are ignored.
module axi_bram_responder
  import axi_bram_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_AW     = 10
) (
  input  logic                    aclk,
  input  logic                    resetn,
  // write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_LSB    = $clog2(STRB_WIDTH);
  localparam logic [MEM_AW-1:0] IDX_ONE = 1;
  localparam logic [LEN_W-1:0]  CNT_ONE = 1;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [MEM_AW-1:0]     r_idx;        // next word to write / read-issue
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;        // W beats taken, or R beats issued to RAM
  logic                  r_werr;       // wlast disagreed with the beat count
  logic                  r_last_was_wr;// arbitration history; reset value favours write
  logic                  r_iss_done;   // all read beats issued to RAM
  logic                  r_s1_vld;     // RAM output register holds an unconsumed beat
  logic [LEN_W-1:0]      r_out_cnt;    // beats moved into the R output register
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [DATA_WIDTH-1:0] r_rdata;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t                w_state_nxt;
  logic                  w_awready;
  logic                  w_arready;
  logic                  w_wready;
  logic                  w_bvalid;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_aw_hs;
  logic                  w_ar_hs;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_s2_load;
  logic                  w_rd_issue;
  logic                  w_ram_en;
  logic [STRB_WIDTH-1:0] w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_unused_addr;

  // Only the word-index slice of each address is meaningful.
  assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and channel readies. Everything is qualified by resetn so
  // the outputs are quiet for the whole reset window, not just after the edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_arready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On contention the channel that did not win last time goes first.
        w_grant_wr = resetn && s_axi_awvalid && (!s_axi_arvalid || !r_last_was_wr);
        w_grant_rd = resetn && s_axi_arvalid && !w_grant_wr;
        w_awready  = w_grant_wr;
        w_arready  = w_grant_rd;
        if (w_grant_wr) begin
          w_state_nxt = ST_WRITE;
        end else if (w_grant_rd) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_WRITE: begin
        w_wready = resetn;
        if (resetn && s_axi_wvalid && (r_cnt == r_len)) begin
          w_state_nxt = ST_WRESP;
        end
      end
      ST_WRESP: begin
        w_bvalid = resetn;
        if (s_axi_bready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (r_rvalid && s_axi_rready && r_rlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_aw_hs = s_axi_awvalid & w_awready;
  assign w_ar_hs = s_axi_arvalid & w_arready;
  assign w_wr_hs = s_axi_wvalid  & w_wready;
  assign w_rd_hs = s_axi_rvalid  & s_axi_rready;

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 1 is the RAM output register, stage 2 the R output
  // register. A new RAM read is issued only when stage 1 is empty or draining
  // this cycle; otherwise the RAM is left disabled so its output holds.
  // ---------------------------------------------------------------------------
  assign w_s2_load  = r_s1_vld && (!r_rvalid || s_axi_rready);
  assign w_rd_issue = resetn && (r_state == ST_READ) && !r_iss_done &&
                      (!r_s1_vld || w_s2_load);

  // Single RAM port shared by both directions; only one burst is live at a time.
  assign w_ram_en = w_wr_hs | w_rd_issue;
  assign w_ram_we = w_wr_hs ? s_axi_wstrb : '0;

  byte_enable_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_AW)
  ) u_ram (
    .i_clk   (aclk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (r_idx),
    .i_wdata (s_axi_wdata),
    .o_rdata (w_ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_id          <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_werr        <= 1'b0;
      r_last_was_wr <= 1'b0;
      r_iss_done    <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_out_cnt     <= '0;
      r_rvalid      <= 1'b0;
      r_rlast       <= 1'b0;
      r_rdata       <= '0;
    end else begin
      if (w_aw_hs) begin
        r_id          <= s_axi_awid;
        r_idx         <= s_axi_awaddr[IDX_LSB +: MEM_AW];
        r_len         <= s_axi_awlen;
        r_cnt         <= '0;
        r_werr        <= 1'b0;
        r_last_was_wr <= 1'b1;
      end else if (w_ar_hs) begin
        r_id          <= s_axi_arid;
        r_idx         <= s_axi_araddr[IDX_LSB +: MEM_AW];
        r_len         <= s_axi_arlen;
        r_cnt         <= '0;
        r_iss_done    <= 1'b0;
        r_out_cnt     <= '0;
        r_last_was_wr <= 1'b0;
      end

      if (w_wr_hs) begin
        r_idx <= r_idx + IDX_ONE;
        r_cnt <= r_cnt + CNT_ONE;
        // wlast must be high on exactly the final beat
        if (s_axi_wlast != (r_cnt == r_len)) begin
          r_werr <= 1'b1;
        end
      end

      if (w_rd_issue) begin
        r_idx <= r_idx + IDX_ONE;
        r_cnt <= r_cnt + CNT_ONE;
        if (r_cnt == r_len) begin
          r_iss_done <= 1'b1;
        end
      end

      if (w_rd_issue) begin
        r_s1_vld <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_vld <= 1'b0;
      end

      if (w_s2_load) begin
        r_rvalid  <= 1'b1;
        r_rdata   <= w_ram_rdata;
        r_rlast   <= (r_out_cnt == r_len);
        r_out_cnt <= r_out_cnt + CNT_ONE;
      end else if (w_rd_hs) begin
        r_rvalid  <= 1'b0;
        r_rlast   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi_awready = w_awready;
  assign s_axi_arready = w_arready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bvalid  = w_bvalid;
  assign s_axi_bid     = r_id;
  assign s_axi_bresp   = (resetn && r_werr) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rid     = r_id;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rlast   = r_rlast & resetn;
  assign s_axi_rvalid  = r_rvalid & resetn;

endmodule

// File: tb/tb_axi_bram_responder.sv
// Purpose : self-checking bench for axi_bram_responder against a byte-level memory model.
// Latency : checks first R beat 2 cycles after AR, 1 beat/cycle with rready high.
// Backpressure: exercises rready toggling/random and delayed bready.
module tb_axi_bram_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int IW    = 8;
  localparam int MAW   = 10;
  localparam int DEPTH = 1 << MAW;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic [IW-1:0] s_axi_awid = '0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [IW-1:0] s_axi_arid = '0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;

  always #5 aclk = ~aclk;

  axi_bram_responder #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ID_WIDTH (IW), .MEM_AW (MAW)
  ) dut (
    .aclk (aclk), .resetn (resetn),
    .s_axi_awid (s_axi_awid), .s_axi_awaddr (s_axi_awaddr), .s_axi_awlen (s_axi_awlen),
    .s_axi_awvalid (s_axi_awvalid), .s_axi_awready (s_axi_awready),
    .s_axi_wdata (s_axi_wdata), .s_axi_wstrb (s_axi_wstrb), .s_axi_wlast (s_axi_wlast),
    .s_axi_wvalid (s_axi_wvalid), .s_axi_wready (s_axi_wready),
    .s_axi_bid (s_axi_bid), .s_axi_bresp (s_axi_bresp), .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_arid (s_axi_arid), .s_axi_araddr (s_axi_araddr), .s_axi_arlen (s_axi_arlen),
    .s_axi_arvalid (s_axi_arvalid), .s_axi_arready (s_axi_arready),
    .s_axi_rid (s_axi_rid), .s_axi_rdata (s_axi_rdata), .s_axi_rresp (s_axi_rresp),
    .s_axi_rlast (s_axi_rlast), .s_axi_rvalid (s_axi_rvalid), .s_axi_rready (s_axi_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference memory: one entry per byte ever written, keyed by word*4+lane.
  logic [7:0] mb [int];

  function automatic int word_of(input logic [31:0] addr, input int beat);
    return int'(((addr / 4) + 32'(beat)) % DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] addr, input int beat,
                             input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++)
      if (s[l]) mb[word_of(addr, beat) * 4 + l] = d[l*8 +: 8];
  endtask

  task automatic model_read(input logic [31:0] addr, input int beat,
                            output logic [31:0] e, output logic [31:0] m);
    e = '0; m = '0;
    for (int l = 0; l < 4; l++) begin
      if (mb.exists(word_of(addr, beat) * 4 + l)) begin
        e[l*8 +: 8] = mb[word_of(addr, beat) * 4 + l];
        m[l*8 +: 8] = 8'hFF;
      end
    end
  endtask

  // All channel tasks start and end on a falling edge.
  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    for (int c = 0; c < 100 && !hs; c++) begin
      #1; hs = s_axi_awready;
      @(negedge aclk);
    end
    s_axi_awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    for (int c = 0; c < 100 && !hs; c++) begin
      #1; hs = s_axi_arready;
      @(negedge aclk);
    end
    s_axi_arvalid = 1'b0;
    chk("ar_handshake", hs, 1);
  endtask

  // W beats; last_at is the beat carrying wlast (-1 for none). After the final
  // beat, one extra beat is offered and must be refused.
  task automatic w_phase(input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] dat [$], input logic [3:0] stb [$],
                         input int last_at);
    bit hs;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        @(negedge aclk);
      end
      s_axi_wvalid = 1'b1; s_axi_wdata = dat[i]; s_axi_wstrb = stb[i];
      s_axi_wlast  = (i == last_at);
      hs = 0;
      for (int c = 0; c < 100 && !hs; c++) begin
        #1; hs = s_axi_wready;
        @(negedge aclk);
      end
      chk("w_handshake", hs, 1);
      if (hs) model_write(addr, i, dat[i], stb[i]);
    end
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
    #1; chk("w_refused_past_len", s_axi_wready, 0);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic get_b(input logic [7:0] id, input logic [1:0] resp);
    bit hs = 0;
    int d = $urandom_range(0, 3);
    s_axi_bready = 1'b0;
    repeat (d) @(negedge aclk);
    s_axi_bready = 1'b1;
    for (int c = 0; c < 100 && !hs; c++) begin
      #1;
      if (s_axi_bvalid) begin
        chk("b_id", s_axi_bid, id);
        chk("b_resp", s_axi_bresp, resp);
        hs = 1;
      end
      @(negedge aclk);
    end
    s_axi_bready = 1'b0;
    chk("b_handshake", hs, 1);
  endtask

  // mode 0: rready always high, 1: toggles every cycle, 2: random.
  // Called on the falling edge right after the AR handshake (k = 0).
  task automatic r_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input int mode, output logic [31:0] d0);
    int nb = 0, k = 0, first = -1, last = -1;
    bit stalled = 0;
    logic [31:0] hold_d, e, m;
    logic hold_l;
    d0 = '0;
    while (nb <= int'(len) && k < 3000) begin
      case (mode)
        0: s_axi_rready = 1'b1;
        1: s_axi_rready = (k % 2 == 0);
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        chk("r_hold_valid", s_axi_rvalid, 1);
        chk("r_hold_data", s_axi_rdata, hold_d);
        chk("r_hold_last", s_axi_rlast, hold_l);
      end
      if (s_axi_rvalid) begin
        if (first < 0) first = k;
        if (s_axi_rready) begin
          model_read(addr, nb, e, m);
          if (m != 0) chk("r_data", s_axi_rdata & m, e & m);
          chk("r_last", s_axi_rlast, nb == int'(len));
          chk("r_id", s_axi_rid, id);
          chk("r_resp", s_axi_rresp, 2'b00);
          if (nb == 0) d0 = s_axi_rdata;
          last = k; nb++; stalled = 0;
        end else begin
          stalled = 1; hold_d = s_axi_rdata; hold_l = s_axi_rlast;
        end
      end
      @(negedge aclk);
      k++;
    end
    s_axi_rready = 1'b0;
    chk("r_beats", nb, int'(len) + 1);
    chk("r_first_latency", first, 2);
    if (mode == 0) chk("r_back_to_back", last - first, int'(len));
  endtask

  task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] dat [$], input logic [3:0] stb [$],
                          input int last_at, input logic [1:0] resp);
    do_aw(id, addr, len);
    w_phase(addr, len, dat, stb, last_at);
    get_b(id, resp);
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int mode, output logic [31:0] d0);
    do_ar(id, addr, len);
    r_phase(id, addr, len, mode, d0);
  endtask

  task automatic fill(input int n, output logic [31:0] dq [$], output logic [3:0] sq [$],
                      input bit rand_strb);
    dq.delete(); sq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back($urandom);
      sq.push_back(rand_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dq [$];
    logic [3:0]  sq [$];
    logic [31:0] d0, addr;
    int nb, w;
    logic [7:0] len;

    // Reset: outputs quiet even with every request asserted
    repeat (2) @(negedge aclk);
    s_axi_awvalid = 1; s_axi_arvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1; s_axi_rready = 1;
    #1;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    s_axi_awvalid = 0; s_axi_arvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
    @(negedge aclk);
    resetn = 1;
    @(negedge aclk);

    // Simultaneous AW/AR out of reset: write first; a repeated clash favours read
    s_axi_awid = 8'h11; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd1; s_axi_awvalid = 1;
    s_axi_arid = 8'h22; s_axi_araddr = 32'h80; s_axi_arlen = 8'd1; s_axi_arvalid = 1;
    #1;
    chk("arb1_awready", s_axi_awready, 1);
    chk("arb1_arready", s_axi_arready, 0);
    @(negedge aclk);
    s_axi_awvalid = 0;
    #1; chk("arb1_ar_blocked_in_write", s_axi_arready, 0);
    dq = '{32'h1111_0000, 32'h1111_0001}; sq = '{4'hF, 4'hF};
    w_phase(32'h80, 8'd1, dq, sq, 1);
    get_b(8'h11, 2'b00);
    s_axi_awid = 8'h33; s_axi_awaddr = 32'h100; s_axi_awlen = 8'd0; s_axi_awvalid = 1;
    #1;
    chk("arb2_arready", s_axi_arready, 1);
    chk("arb2_awready", s_axi_awready, 0);
    @(negedge aclk);
    s_axi_arvalid = 0;
    r_phase(8'h22, 32'h80, 8'd1, 0, d0);
    chk("arb2_read_data", d0, 32'h1111_0000);
    #1; chk("arb3_awready", s_axi_awready, 1);
    @(negedge aclk);
    s_axi_awvalid = 0;
    dq = '{32'h3333_3333}; sq = '{4'hF};
    w_phase(32'h100, 8'd0, dq, sq, 0);
    get_b(8'h33, 2'b00);

    // Four-beat write then read back
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    wr_burst(8'h5A, 32'h10, 8'd3, dq, sq, 3, 2'b00);
    rd_burst(8'h5B, 32'h10, 8'd3, 0, d0);
    chk("dir_first_word", d0, 32'hA0);

    // Byte strobes merge into an existing word
    dq = '{32'hFFFF_FFFF}; sq = '{4'hF};
    wr_burst(8'h01, 32'h40, 8'd0, dq, sq, 0, 2'b00);
    dq = '{32'h0000_1234}; sq = '{4'h3};
    wr_burst(8'h02, 32'h40, 8'd0, dq, sq, 0, 2'b00);
    rd_burst(8'h03, 32'h40, 8'd0, 0, d0);
    chk("strobe_merge", d0, 32'hFFFF_1234);

    // Early wlast: all four beats still taken, SLVERR
    fill(4, dq, sq, 0);
    wr_burst(8'h77, 32'h400, 8'd3, dq, sq, 1, 2'b10);
    rd_burst(8'h78, 32'h400, 8'd3, 0, d0);
    chk("early_wlast_data", d0, dq[0]);

    // Eight-beat read with rready toggling, then with rready held
    fill(8, dq, sq, 0);
    wr_burst(8'h08, 32'h300, 8'd7, dq, sq, 7, 2'b00);
    rd_burst(8'h09, 32'h300, 8'd7, 1, d0);
    rd_burst(8'h0A, 32'h300, 8'd7, 0, d0);

    // Reset in the middle of a sixteen-beat read
    fill(16, dq, sq, 0);
    wr_burst(8'h44, 32'h200, 8'd15, dq, sq, 15, 2'b00);
    do_ar(8'h45, 32'h200, 8'd15);
    nb = 0; s_axi_rready = 1;
    for (int k = 0; k < 50 && nb < 2; k++) begin
      #1; if (s_axi_rvalid) nb++;
      @(negedge aclk);
    end
    chk("rst_mid_beats_before", nb, 2);
    resetn = 0;
    #1; chk("rst_mid_rvalid_now", s_axi_rvalid, 0);
    @(negedge aclk);
    #1;
    chk("rst_mid_rvalid_next", s_axi_rvalid, 0);
    chk("rst_mid_rlast_next", s_axi_rlast, 0);
    resetn = 1; s_axi_rready = 0;
    @(negedge aclk);
    rd_burst(8'h46, 32'h204, 8'd3, 0, d0);
    chk("rst_mid_new_read", d0, dq[1]);

    // Missing wlast on the final beat
    fill(3, dq, sq, 0);
    wr_burst(8'h55, 32'h500, 8'd2, dq, sq, -1, 2'b10);

    // Randomised traffic near both ends of the array, with upper address junk
    for (int t = 0; t < 40; t++) begin
      w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(1005, 1023);
      addr = ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      len = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill(int'(len) + 1, dq, sq, 1);
        wr_burst(8'($urandom), addr, len, dq, sq, int'(len), 2'b00);
      end else begin
        rd_burst(8'($urandom), addr, len, 2, d0);
      end
    end

    // Maximum-length burst, wrapping past the top of the array
    fill(256, dq, sq, 0);
    wr_burst(8'hF0, 32'h8000_0E10, 8'd255, dq, sq, 255, 2'b00);
    rd_burst(8'hF1, 32'h0000_0E10, 8'd255, 0, d0);
    chk("len255_first_word", d0, dq[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
